// File: rtl/sprite_chain_master_if.sv
// Host command channel into the sprite chain master.
// Valid/ready: a command transfers on a clock edge where cmd_valid && cmd_ready; the host holds
// the payload stable while cmd_valid is high and ready is low; ready never depends on valid.
interface sprite_chain_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_sprite_id;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;

  modport master (
    output cmd_valid, cmd_op, cmd_sprite_id, cmd_addr, cmd_data, cmd_x, cmd_y,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sprite_id, cmd_addr, cmd_data, cmd_x, cmd_y,
    output cmd_ready
  );
endinterface

// File: rtl/sprite_chain_master.sv
// Head of the sprite_engine chain: screen scan generator, vblank command replay and
// re-alignment of the colour returned by the last engine with its pixel coordinate.
module sprite_chain_master #(
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int VBLANK_LINES = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CHAIN_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  sprite_chain_master_if.slave    cmd,
  output logic                    prev_enable,
  output logic [5:0]              sprite_id,
  output logic [7:0]              screenX,
  output logic [7:0]              screenY,
  output logic [7:0]              rgbin,
  output logic [5:0]              requested_sprite_id,
  output logic                    program_active,
  output logic [15:0]             mem_address,
  output logic [7:0]              membus,
  output logic [15:0]             set_address,
  output logic [7:0]              setx,
  output logic [7:0]              sety,
  output logic                    clear,
  input  logic [7:0]              chain_rgb,
  output logic                    pix_valid,
  output logic [7:0]              pix_x,
  output logic [7:0]              pix_y,
  output logic [7:0]              pix_rgb,
  output logic [1:0]              state_dbg
);
  localparam int BLANK_CYC = VBLANK_LINES * SCREEN_W;
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]  X_LAST     = 8'(SCREEN_W - 1);
  localparam logic [7:0]  Y_LAST     = 8'(SCREEN_H - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
  localparam bit          CAN_POP    = (BLANK_CYC >= 2);
  localparam logic [15:0] POP_LAST   = CAN_POP ? 16'(BLANK_CYC - 2) : 16'd0;
  localparam logic [PW:0] CNT_FULL   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_SCAN, S_PIDLE, S_PSTROBE, S_PGAP} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  id;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  x;
    logic [7:0]  y;
  } cmd_t;

  state_t         state, next_state;
  logic [7:0]     x_cnt, y_cnt;
  logic [15:0]    bcnt;
  cmd_t           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic           full, push, pop;
  cmd_t           in_cmd, head;
  logic [1:0]     cur_op;
  logic [7:0]     bg_next;
  logic [16:0]    dly [CHAIN_LAT];

  assign full          = (count == CNT_FULL);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign in_cmd        = '{op: cmd.cmd_op, id: cmd.cmd_sprite_id, addr: cmd.cmd_addr,
                           data: cmd.cmd_data, x: cmd.cmd_x, y: cmd.cmd_y};
  assign head          = fifo_mem[rd_ptr];
  assign sprite_id     = 6'd0;
  assign screenX       = x_cnt;
  assign screenY       = y_cnt;

  // A command is only started when its strobe still lands inside the current blank period.
  always_comb begin
    pop = 1'b0;
    if (CAN_POP && (state == S_PIDLE || state == S_PGAP) && count != '0 && bcnt <= POP_LAST)
      pop = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_SCAN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_SCAN:    if (x_cnt == X_LAST && y_cnt == Y_LAST) next_state = S_PIDLE;
      S_PSTROBE: next_state = (bcnt == BLANK_LAST) ? S_SCAN : S_PGAP;
      default: begin
        if (bcnt == BLANK_LAST) next_state = S_SCAN;
        else if (pop)           next_state = S_PSTROBE;
        else                    next_state = S_PIDLE;
      end
    endcase
  end

  // prev_enable is gated by rst so the chain sees no enable while held in reset.
  always_comb begin
    prev_enable    = (state == S_SCAN) && !rst;
    program_active = (state == S_PSTROBE) && (cur_op != 2'b11);
    clear          = (state == S_PSTROBE) && (cur_op == 2'b10);
    state_dbg      = state;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt               <= '0;
      y_cnt               <= '0;
      bcnt                <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      cur_op              <= '0;
      bg_next             <= '0;
      rgbin               <= '0;
      requested_sprite_id <= '0;
      mem_address         <= '0;
      membus              <= '0;
      set_address         <= '0;
      setx                <= '0;
      sety                <= '0;
    end else begin
      if (state == S_SCAN) begin
        bcnt <= '0;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? 8'd0 : y_cnt + 8'd1;
        end else begin
          x_cnt <= x_cnt + 8'd1;
        end
      end else begin
        bcnt <= bcnt + 16'd1;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase

      // Program outputs are loaded at the pop so they are valid throughout the strobe cycle.
      if (pop) begin
        cur_op <= head.op;
        case (head.op)
          2'b00: begin
            requested_sprite_id <= head.id;
            mem_address         <= head.addr;
            membus              <= head.data;
          end
          2'b01: begin
            requested_sprite_id <= head.id;
            set_address         <= head.addr;
            setx                <= head.x;
            sety                <= head.y;
          end
          2'b10:   requested_sprite_id <= head.id;
          default: bg_next <= head.data;
        endcase
      end

      // Background changes only at the frame boundary so a frame never shows two colours.
      if (state != S_SCAN && next_state == S_SCAN) rgbin <= bg_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHAIN_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {prev_enable, x_cnt, y_cnt};
      for (int i = 1; i < CHAIN_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign pix_valid = dly[CHAIN_LAT-1][16];
  assign pix_x     = dly[CHAIN_LAT-1][15:8];
  assign pix_y     = dly[CHAIN_LAT-1][7:0];
  assign pix_rgb   = pix_valid ? chain_rgb : 8'd0;
endmodule

// File: tb/tb_sprite_chain_master.sv
// Bench for sprite_chain_master on a tiny 8x4 screen with one blank line.
module tb_sprite_chain_master;
  localparam int W = 8, H = 4, VB = 1, LAT = 2;
  localparam int VIS = W * H, NBLANK = VB * W, FRAME = VIS + NBLANK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_chain_master_if cif();
  logic        prev_enable, program_active, clear, pix_valid;
  logic [5:0]  sprite_id, requested_sprite_id;
  logic [7:0]  screenX, screenY, rgbin, membus, setx, sety, chain_rgb, pix_x, pix_y, pix_rgb;
  logic [15:0] mem_address, set_address;
  logic [1:0]  state_dbg;

  sprite_chain_master #(.SCREEN_W(W), .SCREEN_H(H), .VBLANK_LINES(VB), .FIFO_DEPTH(4),
                        .CHAIN_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd(cif.slave), .prev_enable(prev_enable), .sprite_id(sprite_id),
    .screenX(screenX), .screenY(screenY), .rgbin(rgbin),
    .requested_sprite_id(requested_sprite_id), .program_active(program_active),
    .mem_address(mem_address), .membus(membus), .set_address(set_address), .setx(setx),
    .sety(sety), .clear(clear), .chain_rgb(chain_rgb), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  id;
    logic [15:0] addr;
    logic [7:0]  data, x, y;
  } cmd_s;

  typedef struct {
    cmd_s        c;
    logic        pa, clr;
    logic [5:0]  rid;
    logic [15:0] maddr, saddr;
    logic [7:0]  mbus, sx, sy;
  } tv_s;

  cmd_s hq[$];
  cmd_s mq[$];
  cmd_s cur;
  tv_s  tv[6];
  int   t, total, bad;
  bit   strobe_now, host_gate, rand_rgb, e_ready, e_pop, e_pv;
  logic [5:0]  e_id;
  logic [15:0] e_maddr, e_saddr;
  logic [7:0]  e_mbus, e_sx, e_sy, e_bg, e_rgb, e_px, e_py, drv_rgb;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Scan position at cycle tt after reset release, straight from the frame arithmetic.
  task automatic scan_at(int tt, output bit v, output logic [7:0] x, output logic [7:0] y);
    int f;
    f = tt % FRAME;
    v = (f < VIS);
    x = v ? 8'(f % W) : 8'd0;
    y = v ? 8'(f / W) : 8'd0;
  endtask

  task automatic model_reset();
    t = 0; strobe_now = 0;
    hq.delete(); mq.delete();
    e_id = 0; e_maddr = 0; e_saddr = 0; e_mbus = 0; e_sx = 0; e_sy = 0; e_bg = 0; e_rgb = 0;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_ready", cif.cmd_ready, 1);      chk("rst_pe", prev_enable, 0);
    chk("rst_x", screenX, 0);                chk("rst_y", screenY, 0);
    chk("rst_rgbin", rgbin, 0);              chk("rst_pa", program_active, 0);
    chk("rst_clear", clear, 0);              chk("rst_rid", requested_sprite_id, 0);
    chk("rst_maddr", mem_address, 0);        chk("rst_mbus", membus, 0);
    chk("rst_saddr", set_address, 0);        chk("rst_setxy", {setx, sety}, 0);
    chk("rst_pix", {pix_valid, pix_x, pix_y, pix_rgb}, 0);
    chk("rst_sid", sprite_id, 0);
  endtask

  task automatic cycle_begin();
    int f;
    bit pv;
    logic [7:0] px, py;
    f = t % FRAME;
    e_ready = (mq.size() < 4);
    e_pop   = (f >= VIS) && (f - VIS <= NBLANK - 2) && (mq.size() > 0) && !strobe_now;
    if (hq.size() > 0 && (host_gate || $urandom_range(0, 1) == 1)) begin
      cif.cmd_valid = 1'b1;   cif.cmd_op = hq[0].op;     cif.cmd_sprite_id = hq[0].id;
      cif.cmd_addr = hq[0].addr; cif.cmd_data = hq[0].data;
      cif.cmd_x = hq[0].x;    cif.cmd_y = hq[0].y;
    end else begin
      cif.cmd_valid = 1'b0;
    end
    pv = 0; px = 0; py = 0;
    if (t >= LAT) scan_at(t - LAT, pv, px, py);
    e_pv = pv; e_px = px; e_py = py;
    drv_rgb = (!rand_rgb && pv) ? px : 8'($urandom);
    chain_rgb = drv_rgb;
  endtask

  task automatic cycle_check();
    bit v;
    logic [7:0] x, y;
    @(negedge clk);
    scan_at(t, v, x, y);
    chk("cmd_ready", cif.cmd_ready, e_ready);
    chk("prev_enable", prev_enable, v);
    chk("screenX", screenX, x);
    chk("screenY", screenY, y);
    chk("sprite_id", sprite_id, 0);
    chk("rgbin", rgbin, e_rgb);
    chk("program_active", program_active, strobe_now && cur.op != 2'b11);
    chk("clear", clear, strobe_now && cur.op == 2'b10);
    chk("req_id", requested_sprite_id, e_id);
    chk("mem_address", mem_address, e_maddr);
    chk("membus", membus, e_mbus);
    chk("set_address", set_address, e_saddr);
    chk("setx", setx, e_sx);
    chk("sety", sety, e_sy);
    chk("pix_valid", pix_valid, e_pv);
    chk("pix_x", pix_x, e_px);
    chk("pix_y", pix_y, e_py);
    chk("pix_rgb", pix_rgb, e_pv ? drv_rgb : 8'd0);
  endtask

  task automatic cycle_end();
    cmd_s c;
    if (e_pop) begin
      c = mq.pop_front();
      case (c.op)
        2'b00: begin e_id = c.id; e_maddr = c.addr; e_mbus = c.data; end
        2'b01: begin e_id = c.id; e_saddr = c.addr; e_sx = c.x; e_sy = c.y; end
        2'b10: e_id = c.id;
        default: e_bg = c.data;
      endcase
      cur = c;
    end
    if (cif.cmd_valid && e_ready) mq.push_back(hq.pop_front());
    strobe_now = e_pop;
    if (t % FRAME == FRAME - 1) e_rgb = e_bg;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run(int n);
    repeat (n) begin
      cycle_begin();
      cycle_check();
      cycle_end();
    end
  endtask

  function automatic cmd_s mk(logic [1:0] op, logic [5:0] id, logic [15:0] addr,
                              logic [7:0] data, logic [7:0] x, logic [7:0] y);
    cmd_s c;
    c.op = op; c.id = id; c.addr = addr; c.data = data; c.x = x; c.y = y;
    return c;
  endfunction

  task automatic set_tv(int i, cmd_s c, logic pa, logic clr, logic [5:0] rid,
                        logic [15:0] maddr, logic [7:0] mbus, logic [15:0] saddr,
                        logic [7:0] sx, logic [7:0] sy);
    tv[i].c = c; tv[i].pa = pa; tv[i].clr = clr; tv[i].rid = rid; tv[i].maddr = maddr;
    tv[i].mbus = mbus; tv[i].saddr = saddr; tv[i].sx = sx; tv[i].sy = sy;
  endtask

  initial begin
    int mask;
    total = 0; bad = 0; host_gate = 1; rand_rgb = 0; t = 0;
    cif.cmd_valid = 0; cif.cmd_op = 0; cif.cmd_sprite_id = 0; cif.cmd_addr = 0;
    cif.cmd_data = 0; cif.cmd_x = 0; cif.cmd_y = 0; chain_rgb = 0;
    model_reset();

    set_tv(0, mk(2'd0, 6'd3,  16'h0012, 8'hA5, 8'h00, 8'h00), 1, 0, 6'd3,  16'h0012, 8'hA5, 16'h0000, 8'h00, 8'h00);
    set_tv(1, mk(2'd1, 6'd5,  16'h0340, 8'h77, 8'h10, 8'h20), 1, 0, 6'd5,  16'h0012, 8'hA5, 16'h0340, 8'h10, 8'h20);
    set_tv(2, mk(2'd2, 6'd9,  16'hFFFF, 8'h11, 8'h01, 8'h02), 1, 1, 6'd9,  16'h0012, 8'hA5, 16'h0340, 8'h10, 8'h20);
    set_tv(3, mk(2'd3, 6'd7,  16'h0001, 8'h1C, 8'h03, 8'h04), 0, 0, 6'd9,  16'h0012, 8'hA5, 16'h0340, 8'h10, 8'h20);
    set_tv(4, mk(2'd0, 6'd63, 16'hFFFF, 8'hFF, 8'h00, 8'h00), 1, 0, 6'd63, 16'hFFFF, 8'hFF, 16'h0340, 8'h10, 8'h20);
    set_tv(5, mk(2'd1, 6'd0,  16'h0000, 8'h00, 8'hFF, 8'h00), 1, 0, 6'd0,  16'hFFFF, 8'hFF, 16'h0000, 8'hFF, 8'h00);

    repeat (2) @(posedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // Plain frame: scan order, blank period, chain colour equals pixel x.
    run(FRAME);

    // One command per frame, strobe expected at blank cycle 1.
    for (int i = 0; i < 6; i++) begin
      hq.push_back(tv[i].c);
      for (int k = 0; k < FRAME; k++) begin
        cycle_begin();
        cycle_check();
        if (k == VIS + 1) begin
          chk("tv_pa", program_active, tv[i].pa);
          chk("tv_clear", clear, tv[i].clr);
          chk("tv_rid", requested_sprite_id, tv[i].rid);
          chk("tv_maddr", mem_address, tv[i].maddr);
          chk("tv_mbus", membus, tv[i].mbus);
          chk("tv_saddr", set_address, tv[i].saddr);
          chk("tv_sx", setx, tv[i].sx);
          chk("tv_sy", sety, tv[i].sy);
        end
        cycle_end();
      end
    end
    chk("bg_applied", rgbin, 8'h1C);

    // Five back-to-back commands: FIFO fills after four, strobes every other blank cycle.
    for (int i = 0; i < 5; i++) hq.push_back(mk(2'd0, 6'(i + 1), 16'(16'h0100 + i), 8'(8'h40 + i), 8'h00, 8'h00));
    mask = 0;
    for (int k = 0; k < FRAME; k++) begin
      cycle_begin();
      cycle_check();
      if (k == 4) chk("ready_full", cif.cmd_ready, 0);
      if (k >= VIS && program_active === 1'b1) mask |= (1 << (k - VIS));
      cycle_end();
    end
    chk("strobe_mask", mask, 32'hAA);
    run(FRAME);

    // Reset in the middle of a strobe: program_active drops at once, command is dropped.
    hq.push_back(mk(2'd0, 6'd2, 16'h0777, 8'h3C, 8'h00, 8'h00));
    run(VIS + 1);
    chk("pa_pre_rst", program_active, 1);
    rst = 1;
    #1;
    chk("pa_async", program_active, 0);
    chk("pe_async", prev_enable, 0);
    cif.cmd_valid = 0;
    reset_checks();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    run(FRAME + 4);

    // Random host traffic, random valid gaps and random chain colours.
    host_gate = 0; rand_rgb = 1;
    for (int k = 0; k < 12 * FRAME; k++) begin
      if ($urandom_range(0, 11) == 0)
        hq.push_back(mk(2'($urandom_range(0, 3)), 6'($urandom), 16'($urandom), 8'($urandom),
                        8'($urandom), 8'($urandom)));
      run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
